// File: rtl/irq_prio_serializer.sv
// Pending-register interrupt serializer: captures eight request lines and presents
// them one at a time, highest index first, as a 3-bit index on a valid/ready handshake.
module irq_prio_serializer #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ready,
  input  logic       clr_ovr,
  output logic [2:0] pos,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overrun
);

  logic [7:0] req_q;
  logic [7:0] pending_q, pending_d;
  logic [2:0] pos_q, pos_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;

  logic [7:0] set_v;
  logic [7:0] clr_v;
  logic [7:0] cand;
  logic       acc;

  function automatic logic [2:0] msb_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

  always_comb begin
    set_v     = '0;
    clr_v     = '0;
    acc       = valid_q & ready;
    pos_d     = pos_q;
    valid_d   = valid_q;

    if (EDGE) set_v = req & ~req_q & mask;
    else      set_v = req & mask;

    if (acc) clr_v = onehot(pos_q);

    // Candidates come from the registered pending word; same-cycle captures wait a cycle.
    cand      = pending_q & ~clr_v;
    pending_d = cand | set_v;
    overrun_d = (overrun_q & ~clr_ovr) | (|(set_v & cand));

    if (!valid_q || acc) begin
      if (|cand) begin
        pos_d   = msb_index(cand);
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      pending_q <= '0;
      pos_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      req_q     <= req;
      pending_q <= pending_d;
      pos_q     <= pos_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign pos     = pos_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_irq_prio_serializer.sv
// Bench for irq_prio_serializer: directed scenarios on the edge-capture instance plus
// randomized traffic on edge and level instances against a behavioural model.
module tb_irq_prio_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req, mask;
  logic       ready, clr_ovr;

  logic [2:0] pos_e, pos_l;
  logic       valid_e, valid_l;
  logic [7:0] pend_e, pend_l;
  logic       ovr_e, ovr_l;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  irq_prio_serializer #(.EDGE(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ready(ready), .clr_ovr(clr_ovr),
    .pos(pos_e), .valid(valid_e), .pending(pend_e), .overrun(ovr_e)
  );

  irq_prio_serializer #(.EDGE(1'b0)) dut_lvl (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ready(ready), .clr_ovr(clr_ovr),
    .pos(pos_l), .valid(valid_l), .pending(pend_l), .overrun(ovr_l)
  );

  typedef struct packed {
    logic [7:0] pend;
    logic [7:0] reqq;
    logic [2:0] pos;
    logic       vld;
    logic       ovr;
  } mstate_t;

  mstate_t m_e, m_l;

  // Behavioural reference: one clock of the serializer, bit by bit.
  function automatic mstate_t step(input mstate_t s, input bit edge_mode,
                                   input logic [7:0] r, input logic [7:0] m,
                                   input logic rdy, input logic co);
    mstate_t    n;
    logic [7:0] setv, cand;
    bit         acc, dup, found;
    n     = s;
    dup   = 0;
    found = 0;
    for (int i = 0; i < 8; i++)
      setv[i] = m[i] & (edge_mode ? (r[i] & ~s.reqq[i]) : r[i]);
    acc  = s.vld & rdy;
    cand = s.pend;
    if (acc) cand[s.pos] = 1'b0;
    for (int i = 0; i < 8; i++)
      if (setv[i] && cand[i]) dup = 1;
    n.ovr = (s.ovr & ~co) | dup;
    if (!s.vld || acc) begin
      n.vld = 1'b0;
      for (int i = 7; i >= 0; i--) begin
        if (cand[i] && !found) begin
          n.pos = 3'(i);
          n.vld = 1'b1;
          found = 1;
        end
      end
    end
    n.pend = cand | setv;
    n.reqq = r;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e <= '0;
      m_l <= '0;
    end else begin
      m_e <= step(m_e, 1'b1, req, mask, ready, clr_ovr);
      m_l <= step(m_l, 1'b0, req, mask, ready, clr_ovr);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 8'hFF; mask = 8'hFF; ready = 1'b0; clr_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pos_e, valid_e, pend_e, ovr_e} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got pos=%0d valid=%0b pending=%h overrun=%0b, expected all 0",
               pos_e, valid_e, pend_e, ovr_e);
    end
    ready = 1'b1;
    rst   = 1'b0;
    tick();
    checks++;
    if (pend_e !== 8'hFF || valid_e !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_capture: got pending=%h valid=%0b, expected pending=ff valid=0",
               pend_e, valid_e);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (valid_e !== 1'b1 || pos_e !== 3'(7 - k)) begin
        fails++;
        $display("FAIL reset_drain_%0d: got valid=%0b pos=%0d, expected valid=1 pos=%0d",
                 k, valid_e, pos_e, 7 - k);
      end
    end
    tick();
    checks++;
    if (valid_e !== 1'b0 || pend_e !== 8'h00) begin
      fails++;
      $display("FAIL reset_drain_end: got valid=%0b pending=%h, expected valid=0 pending=00",
               valid_e, pend_e);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_single_pulse;
    req = 8'h08;
    tick();
    req = 8'h00;
    checks++;
    if (pend_e !== 8'h08 || valid_e !== 1'b0) begin
      fails++;
      $display("FAIL single_capture: got pending=%h valid=%0b, expected pending=08 valid=0",
               pend_e, valid_e);
    end
    tick();
    checks++;
    if (valid_e !== 1'b1 || pos_e !== 3'd3) begin
      fails++;
      $display("FAIL single_present: got valid=%0b pos=%0d, expected valid=1 pos=3", valid_e, pos_e);
    end
    tick();
    checks++;
    if (valid_e !== 1'b0 || pend_e !== 8'h00) begin
      fails++;
      $display("FAIL single_done: got valid=%0b pending=%h, expected valid=0 pending=00",
               valid_e, pend_e);
    end
  endtask

  task automatic test_burst;
    int exp_seq[4] = '{7, 5, 2, 0};
    req = 8'b1010_0101;
    tick();
    req = 8'h00;
    checks++;
    if (pend_e !== 8'hA5) begin
      fails++;
      $display("FAIL burst_capture: got pending=%h, expected a5", pend_e);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (valid_e !== 1'b1 || pos_e !== 3'(exp_seq[k])) begin
        fails++;
        $display("FAIL burst_seq_%0d: got valid=%0b pos=%0d, expected valid=1 pos=%0d",
                 k, valid_e, pos_e, exp_seq[k]);
      end
    end
    tick();
    checks++;
    if (valid_e !== 1'b0 || ovr_e !== 1'b0 || pend_e !== 8'h00) begin
      fails++;
      $display("FAIL burst_end: got valid=%0b overrun=%0b pending=%h, expected 0 0 00",
               valid_e, ovr_e, pend_e);
    end
  endtask

  task automatic test_backpressure;
    ready = 1'b0;
    req   = 8'h04;
    tick();
    req = 8'h00;
    tick();
    checks++;
    if (valid_e !== 1'b1 || pos_e !== 3'd2) begin
      fails++;
      $display("FAIL bp_present: got valid=%0b pos=%0d, expected valid=1 pos=2", valid_e, pos_e);
    end
    req = 8'h40;
    tick();
    req = 8'h00;
    checks++;
    if (valid_e !== 1'b1 || pos_e !== 3'd2 || pend_e !== 8'b0100_0100) begin
      fails++;
      $display("FAIL bp_hold: got valid=%0b pos=%0d pending=%h, expected valid=1 pos=2 pending=44",
               valid_e, pos_e, pend_e);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (valid_e !== 1'b1 || pos_e !== 3'd6 || pend_e !== 8'h40) begin
      fails++;
      $display("FAIL bp_next: got valid=%0b pos=%0d pending=%h, expected valid=1 pos=6 pending=40",
               valid_e, pos_e, pend_e);
    end
    tick();
    checks++;
    if (valid_e !== 1'b0 || pend_e !== 8'h00) begin
      fails++;
      $display("FAIL bp_done: got valid=%0b pending=%h, expected valid=0 pending=00", valid_e, pend_e);
    end
  endtask

  task automatic test_overrun;
    ready = 1'b0;
    req   = 8'h02;
    tick();
    req = 8'h00;
    tick();
    checks++;
    if (ovr_e !== 1'b0) begin
      fails++;
      $display("FAIL ovr_first: got overrun=%0b, expected 0", ovr_e);
    end
    req = 8'h02;
    tick();
    req = 8'h00;
    checks++;
    if (ovr_e !== 1'b1) begin
      fails++;
      $display("FAIL ovr_set: got overrun=%0b, expected 1", ovr_e);
    end
    tick();
    checks++;
    if (ovr_e !== 1'b1) begin
      fails++;
      $display("FAIL ovr_sticky: got overrun=%0b, expected 1", ovr_e);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    checks++;
    if (ovr_e !== 1'b0) begin
      fails++;
      $display("FAIL ovr_clear: got overrun=%0b, expected 0", ovr_e);
    end
    clr_ovr = 1'b1;
    req     = 8'h02;
    tick();
    clr_ovr = 1'b0;
    req     = 8'h00;
    checks++;
    if (ovr_e !== 1'b1) begin
      fails++;
      $display("FAIL ovr_clear_vs_new: got overrun=%0b, expected 1", ovr_e);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (valid_e !== 1'b0 || pend_e !== 8'h00) begin
      fails++;
      $display("FAIL ovr_drain: got valid=%0b pending=%h, expected valid=0 pending=00", valid_e, pend_e);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
  endtask

  task automatic test_mask;
    mask = 8'h0F;
    req  = 8'hF0;
    tick();
    checks++;
    if (pend_e !== 8'h00 || valid_e !== 1'b0) begin
      fails++;
      $display("FAIL mask_capture: got pending=%h valid=%0b, expected 00 0", pend_e, valid_e);
    end
    tick();
    checks++;
    if (valid_e !== 1'b0) begin
      fails++;
      $display("FAIL mask_valid: got valid=%0b, expected 0", valid_e);
    end
    req  = 8'h00;
    mask = 8'hFF;
    tick();
  endtask

  task automatic test_async_reset;
    ready = 1'b0;
    req   = 8'h0C;
    tick();
    req = 8'h00;
    tick();
    checks++;
    if (pend_e !== 8'h0C || valid_e !== 1'b1 || pos_e !== 3'd3) begin
      fails++;
      $display("FAIL areset_setup: got pending=%h valid=%0b pos=%0d, expected 0c 1 3",
               pend_e, valid_e, pos_e);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pos_e, valid_e, pend_e, ovr_e} !== 13'd0) begin
      fails++;
      $display("FAIL areset_immediate: got pos=%0d valid=%0b pending=%h overrun=%0b, expected all 0",
               pos_e, valid_e, pend_e, ovr_e);
    end
    tick();
    rst   = 1'b0;
    ready = 1'b1;
    tick();
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      checks++;
      if ({pos_e, valid_e, pend_e, ovr_e} !== {m_e.pos, m_e.vld, m_e.pend, m_e.ovr}) begin
        fails++;
        $display("FAIL rand_edge_%0d: got pos=%0d valid=%0b pending=%h overrun=%0b, expected %0d %0b %h %0b",
                 i, pos_e, valid_e, pend_e, ovr_e, m_e.pos, m_e.vld, m_e.pend, m_e.ovr);
      end
      checks++;
      if ({pos_l, valid_l, pend_l, ovr_l} !== {m_l.pos, m_l.vld, m_l.pend, m_l.ovr}) begin
        fails++;
        $display("FAIL rand_level_%0d: got pos=%0d valid=%0b pending=%h overrun=%0b, expected %0d %0b %h %0b",
                 i, pos_l, valid_l, pend_l, ovr_l, m_l.pos, m_l.vld, m_l.pend, m_l.ovr);
      end
      req     = 8'($urandom) & 8'($urandom);
      mask    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      ready   = ($urandom_range(0, 3) != 0);
      clr_ovr = ($urandom_range(0, 15) == 0);
      rst     = (i == 200);
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; mask = 8'hFF; ready = 1'b0; clr_ovr = 1'b0;
    test_reset();
    test_single_pulse();
    test_burst();
    test_backpressure();
    test_overrun();
    test_mask();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
